// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: score width, boundary constants,
// base encoding and the feeder state type. Imported by the PE array,
// the result collector and the feeder.
package sw_pkg;

    localparam int unsigned W = 12;

    // Boundary "minus infinity" for the F (gap) recurrence.
    localparam logic [11:0] NINF = 12'b1110_0000_0000;

    typedef logic [1:0] base_t;

    localparam base_t BASE_A = 2'd0;
    localparam base_t BASE_C = 2'd1;
    localparam base_t BASE_G = 2'd2;
    localparam base_t BASE_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DROP   = 3'd2,
        ST_STREAM = 3'd3,
        ST_GAP    = 3'd4
    } sw_feeder_state_t;

endpackage

// File: rtl/sw_feeder_if.sv
// Feeder bus: host-side ready/valid base stream plus the PE0 boundary
// outputs. The feeder takes the slave side, the host/bench the master side.
interface sw_feeder_if #(
    parameter int unsigned W = 12
);
    import sw_pkg::*;

    logic         in_valid;
    logic         in_ready;
    base_t        in_base;
    logic         in_last;
    base_t        t_out;
    logic [W-1:0] v_out;
    logic [W-1:0] f_out;
    logic [W-1:0] max_out;
    logic         valid_out;

    modport master (
        output in_valid, in_base, in_last,
        input  in_ready, t_out, v_out, f_out, max_out, valid_out
    );

    modport slave (
        input  in_valid, in_base, in_last,
        output in_ready, t_out, v_out, f_out, max_out, valid_out
    );

endinterface

// File: rtl/sw_feeder_mem.sv
// Target sequence buffer: DEPTH x 2-bit simple dual-port RAM, synchronous
// write, registered read with one cycle of latency. Contents are not reset.
// The read register returns zero on cycles without a read so it can drive
// t_out directly and stay at zero outside a burst.
module sw_feeder_mem
    import sw_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] waddr,
    input  base_t         wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] raddr,
    output base_t         rdata
);

    base_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; zero when no read was issued.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/sw_feeder.sv
// Upstream feeder for the Smith-Waterman PE array. Buffers a whole target
// sequence from the host, then plays it to PE0 as one gap-free valid burst
// followed by GAP_CYCLES invalid cycles so every PE returns to idle.
// Optional feature: define SW_FEEDER_ERR_EN to add a sticky truncation flag
// output `err`.
module sw_feeder
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned W          = sw_pkg::W,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    sw_feeder_if.slave bus,
    output logic       busy
`ifdef SW_FEEDER_ERR_EN
    ,
    output logic       err
`endif
);

    import sw_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1) + 1;

    localparam logic [PW-1:0] LAST_ENTRY = PW'(DEPTH - 1);
    localparam logic [PW-1:0] FULL_LEN   = PW'(DEPTH);
    localparam logic [GW-1:0] GAP_END    = GW'(GAP_CYCLES);
    localparam logic [W-1:0]  F_NINF     = W'($signed(NINF));

    sw_feeder_state_t state_q, state_d;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] len_q;
    logic [GW-1:0] gap_q;
    logic          in_ready_q;
    logic          valid_q;
    logic [W-1:0]  f_q;
    logic          busy_q;

    logic  beat;
    logic  loading;
    logic  wr_en;
    logic  rd_en;
    base_t rd_data;

    assign beat    = bus.in_valid && in_ready_q;
    assign loading = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign wr_en   = beat && loading;
    assign rd_en   = (state_q == ST_STREAM) && !rst;

    sw_feeder_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .wr_en (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.in_base),
        .rd_en (rd_en),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_data)
    );

    // Next-state selection. IDLE and LOAD share the write path because
    // wr_ptr is zero in IDLE, so the first beat follows the same rules.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (beat) begin
                    if (bus.in_last) begin
                        state_d = ST_STREAM;
                    end else if (wr_ptr_q == LAST_ENTRY) begin
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DROP: begin
                if (beat && bus.in_last) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (rd_ptr_q == len_q - PW'(1)) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // GAP also covers the cycle carrying the last read result,
                // hence GAP_CYCLES+1 cycles in this state.
                if (gap_q == GAP_END) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointers, length and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            f_q        <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                          (state_d == ST_DROP);
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= (state_q == ST_STREAM);
            f_q        <= (state_q == ST_STREAM) ? F_NINF : '0;

            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                if (bus.in_last) begin
                    len_q <= wr_ptr_q + PW'(1);
                end else if (wr_ptr_q == LAST_ENTRY) begin
                    len_q <= FULL_LEN;
                end
            end

            if (state_q == ST_STREAM) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end

            if (state_q == ST_GAP) begin
                gap_q <= gap_q + GW'(1);
            end else begin
                gap_q <= '0;
            end

            if (state_d == ST_IDLE) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end
        end
    end

`ifdef SW_FEEDER_ERR_EN
    logic err_q;

    // Sticky truncation flag, set together with entry to DROP.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (loading && state_d == ST_DROP) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.valid_out = valid_q;
    assign bus.t_out     = rd_data;
    assign bus.f_out     = f_q;
    assign bus.v_out     = '0;
    assign bus.max_out   = '0;
    assign busy          = busy_q;

endmodule
